fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised next-generation fetch stage. Replaces the free-running PC incrementer with a request/response fetch engine to instruction memory.
- Issues word-aligned fetch requests from a fetch PC and tolerates variable memory latency with in-order responses.
- Buffers fetched {pc, insn} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight instructions.

Parameters:
- DWIDTH, 32, instruction width in bits
- AWIDTH, 32, address / PC width in bits
- BASEADDR, 32'h01000000, PC value after reset
- IBUF_DEPTH, 4, instruction buffer entries (power of 2, >= 2); also the maximum number of outstanding requests

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- redirect_valid_i  input  1  redirect fetch PC this cycle
- redirect_pc_i  input  AWIDTH  redirect target
- imem_req_valid_o  output  1  fetch request valid
- imem_req_addr_o  output  AWIDTH  fetch request address
- imem_req_ready_i  input  1  memory accepts request
- imem_rsp_valid_i  input  1  response valid (in order, one per accepted request)
- imem_rsp_data_i  input  DWIDTH  response instruction word
- insn_valid_o  output  1  buffered instruction available
- insn_ready_i  input  1  decode consumes instruction
- pc_o  output  AWIDTH  PC of the head instruction
- insn_o  output  DWIDTH  head instruction

Behaviour:
- Reset (clk and rst as in the existing codebase; reset is synchronous, active-high):
  - fetch_pc = BASEADDR; buffer empty; outstanding = 0; stale = 0; state = RUN.
  - Outputs: imem_req_valid_o = 0, insn_valid_o = 0, pc_o = 0, insn_o = 0.
  - Reset mid-operation discards everything. Memory is reset on the same rst, so no responses arrive after reset.
- Request issue:
  - imem_req_valid_o = (state == RUN) && (occupancy + outstanding < IBUF_DEPTH) && !rst.
  - imem_req_addr_o = fetch_pc.
  - On the valid && ready handshake: fetch_pc += 4 (wraps modulo 2^AWIDTH) and outstanding++.
  - Valid is held, with a stable address, until ready is asserted.
- Response:
  - On imem_rsp_valid_i: outstanding--.
  - If stale > 0, stale-- and the data is dropped.
  - Otherwise {pc of the oldest issued request, data} is pushed into the buffer. A PC shadow FIFO tracks the PCs of requests in flight.
  - The buffer cannot overflow, because of the issue rule.
- Output:
  - insn_valid_o = buffer not empty; pc_o and insn_o show the head entry.
  - The head is popped on valid && ready.
  - When the buffer is empty, pc_o and insn_o hold their last value.
  - Same-cycle push and pop is allowed when the buffer is full or empty. Empty pass-through takes 1 cycle: no combinational path from rsp to insn_valid_o.
- Redirect (redirect_valid_i = 1):
  - The buffer is flushed, and a same-cycle pop is ignored.
  - fetch_pc = redirect_pc_i.
  - stale = outstanding after this cycle's updates: it counts a request accepted this cycle and excludes a response arriving this cycle, which is itself dropped.
  - If stale > 0, go to DRAIN; otherwise stay in RUN.
  - A second redirect while in DRAIN takes the new target and recomputes stale the same way.
- State machine:
  - RUN: normal operation.
  - DRAIN: no requests issued; leave for RUN when stale reaches 0.
- Widths:
  - occupancy and outstanding are $clog2(IBUF_DEPTH)+1 bits.
  - redirect_pc_i[1:0] is used as given unless FETCH_MISALIGN_EN is defined.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0] != 0 sets misalign_o sticky until rst.
  - That redirect still flushes, but the unit enters DRAIN and stays there with no further requests (halt).
- Undefined:
  - No port is added; the low address bits are passed unchecked.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_state_e {RUN, DRAIN}
  - struct fetch_entry_t {pc, insn}
  - localparam PC_STEP = 4
- Sub-module fetch_fifo: parametrised synchronous FIFO (WIDTH, DEPTH) with flush, push, pop, full, empty and count.
- fetch_fifo is instantiated twice: once for the instruction buffer and once for the in-flight PC shadow.

Test Plan:
- Reset, ready always 1, 1-cycle memory, decode ready 1:
  - requests at 0x01000000, 0x01000004, 0x01000008, ...
  - pc_o follows one instruction per cycle after the first response.
- Decode ready held 0, IBUF_DEPTH=4:
  - exactly 4 requests accepted, then imem_req_valid_o = 0.
  - Releasing ready resumes issue and preserves order.
- imem_req_ready_i low for 3 cycles:
  - valid and addr 0x01000004 held stable.
  - fetch_pc advances only on the handshake.
- Redirect to 0x01000100 with 2 outstanding and a 3-cycle memory latency:
  - buffer flushed; the 2 responses are dropped; state returns to RUN.
  - next request is 0x01000100; first delivered pc_o = 0x01000100.
- Redirect in the same cycle as a response and a pop:
  - response dropped; no pop takes effect.
  - insn_valid_o = 0 the next cycle.
- rst asserted mid-stream with 3 outstanding:
  - all outputs are at their reset values the next cycle.
  - first request is 0x01000000.
- (FETCH_MISALIGN_EN) redirect to 0x01000102:
  - misalign_o = 1 and no further requests.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, default {pc, insn} entry layout and the PC increment.
package fetch_pkg;

    localparam int FETCH_AWIDTH = 32;
    localparam int FETCH_DWIDTH = 32;
    localparam int PC_STEP      = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_AWIDTH-1:0] pc;
        logic [FETCH_DWIDTH-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head entry is readable in the same cycle it is valid.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is never reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PW+1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Request/response instruction fetch with in-flight PC tracking, decode buffer and redirect flush/drain.
// Optional FETCH_MISALIGN_EN: a misaligned redirect target raises sticky misalign_o and halts fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DWIDTH     = 32,
    parameter int                AWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASEADDR   = 32'h01000000,
    parameter int                IBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_req_ready_i,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
`ifdef FETCH_MISALIGN_EN
    output logic              misalign_o,
`endif
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
);
    localparam int              CW      = $clog2(IBUF_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(IBUF_DEPTH);

    fetch_state_e             state_reg, state_next;
    logic [AWIDTH-1:0]        fetch_pc_reg;
    logic [AWIDTH-1:0]        last_pc_reg;
    logic [DWIDTH-1:0]        last_insn_reg;
    logic [CW-1:0]            stale_reg, stale_next;
    logic [CW-1:0]            occupancy, outstanding, outstanding_next;
    logic                     req_fire, drop, halt;
    logic                     ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
    logic                     shadow_full, shadow_empty;
    logic [AWIDTH-1:0]        shadow_head;
    logic [AWIDTH+DWIDTH-1:0] ibuf_head;
    logic                     unused_flags;

    // The shadow FIFO holds one PC per accepted request, so its count is the outstanding count.
    fetch_fifo #(.WIDTH(AWIDTH), .DEPTH(IBUF_DEPTH)) u_shadow (
        .clk(clk), .rst(rst), .flush(1'b0),
        .push(req_fire), .push_data(fetch_pc_reg),
        .pop(imem_rsp_valid_i), .head(shadow_head),
        .full(shadow_full), .empty(shadow_empty), .count(outstanding)
    );

    fetch_fifo #(.WIDTH(AWIDTH + DWIDTH), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk), .rst(rst), .flush(redirect_valid_i),
        .push(ibuf_push), .push_data({shadow_head, imem_rsp_data_i}),
        .pop(ibuf_pop), .head(ibuf_head),
        .full(ibuf_full), .empty(ibuf_empty), .count(occupancy)
    );

    assign unused_flags     = ^{ibuf_full, shadow_full, shadow_empty};
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign drop             = redirect_valid_i || (stale_reg != '0);
    assign ibuf_push        = imem_rsp_valid_i && !drop;
    assign ibuf_pop         = insn_valid_o && insn_ready_i && !redirect_valid_i;
    assign outstanding_next = outstanding + {{(CW-1){1'b0}}, req_fire}
                                          - {{(CW-1){1'b0}}, imem_rsp_valid_i};

`ifdef FETCH_MISALIGN_EN
    logic misalign_reg;
    logic misalign_set;
    assign misalign_set = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else if (misalign_set) begin
            misalign_reg <= 1'b1;
        end
    end
    assign halt       = misalign_reg || misalign_set;
    assign misalign_o = misalign_reg;
`else
    assign halt = 1'b0;
`endif

    // A redirect counts a request accepted this cycle as stale and drops this cycle's response.
    always_comb begin
        stale_next = stale_reg;
        if (redirect_valid_i) begin
            stale_next = outstanding_next;
        end else if (imem_rsp_valid_i && (stale_reg != '0)) begin
            stale_next = stale_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == RUN) begin
            if (redirect_valid_i && (stale_next != '0)) begin
                state_next = DRAIN;
            end
        end else if (stale_next == '0) begin
            state_next = RUN;
        end
        if (halt) begin
            state_next = DRAIN;
        end
    end

    always_comb begin
        imem_req_valid_o = (state_reg == RUN) && ((occupancy + outstanding) < DEPTH_C) && !rst;
        imem_req_addr_o  = fetch_pc_reg;
        insn_valid_o     = !ibuf_empty;
        pc_o             = ibuf_empty ? last_pc_reg   : ibuf_head[AWIDTH+DWIDTH-1:DWIDTH];
        insn_o           = ibuf_empty ? last_insn_reg : ibuf_head[DWIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= BASEADDR;
            stale_reg     <= '0;
            last_pc_reg   <= '0;
            last_insn_reg <= '0;
        end else begin
            if (redirect_valid_i) begin
                fetch_pc_reg <= redirect_pc_i;
            end else if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + AWIDTH'(PC_STEP);
            end
            stale_reg <= stale_next;
            // Remember the displayed head so the outputs hold once the buffer drains.
            if (!ibuf_empty) begin
                last_pc_reg   <= ibuf_head[AWIDTH+DWIDTH-1:DWIDTH];
                last_insn_reg <= ibuf_head[DWIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an in-order memory model and an output monitor share expectation queues.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] pc;
    logic [31:0] insn;
`ifdef FETCH_MISALIGN_EN
    logic        misalign;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    int          epoch  = 0;
    int          n_req  = 0;
    int          n_out  = 0;
    logic [31:0] exp_addr = BASE;

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { fetch_entry_t e; int epoch; } exp_t;
    mem_req_t mem_q[$];
    exp_t     exp_q[$];

    fetch_unit #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .imem_req_valid_o(imem_req_valid), .imem_req_addr_o(imem_req_addr),
        .imem_req_ready_i(imem_req_ready),
        .imem_rsp_valid_i(imem_rsp_valid), .imem_rsp_data_i(imem_rsp_data),
`ifdef FETCH_MISALIGN_EN
        .misalign_o(misalign),
`endif
        .insn_valid_o(insn_valid), .insn_ready_i(insn_ready),
        .pc_o(pc), .insn_o(insn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model and output monitor: sample at negedge, drive the response for the next edge.
    initial begin
        exp_t     x;
        mem_req_t m;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
                exp_q.delete();
                exp_addr       = BASE;
                epoch++;
                imem_rsp_valid = 1'b0;
            end else begin
                if (insn_valid && insn_ready && !redirect_valid) begin
                    while (exp_q.size() > 0 && exp_q[0].epoch != epoch) void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got pc %0h, expected no instruction", pc);
                    end else begin
                        x = exp_q.pop_front();
                        $display("out  pc=%08h insn=%08h", pc, insn);
                        check("out_pc", pc, x.e.pc);
                        check("out_insn", insn, x.e.insn);
                        n_out++;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    $display("req  addr=%08h", imem_req_addr);
                    check("req_addr", imem_req_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    m.addr = imem_req_addr;
                    m.due  = cyc + lat;
                    mem_q.push_back(m);
                    x.e.pc   = imem_req_addr;
                    x.e.insn = insn_of(imem_req_addr);
                    x.epoch  = epoch;
                    exp_q.push_back(x);
                    n_req++;
                end
                if (redirect_valid) begin
                    exp_addr = redirect_pc;
                    epoch++;
                end
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = insn_of(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit got;
        int i;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; insn_ready = 1'b1;
        step(2);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_insn_valid", insn_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_insn", insn, 0);
`ifdef FETCH_MISALIGN_EN
        check("rst_misalign", misalign, 0);
`endif
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, BASE);

        // Streaming with 1-cycle memory: one instruction per cycle.
        step(12);
        n0 = n_out;
        step(8);
        check("stream_rate", n_out - n0, 8);

        // Decode stalled from reset: exactly IBUF_DEPTH requests.
        rst = 1'b1; insn_ready = 1'b0;
        step(1);
        rst = 1'b0; n0 = n_req;
        step(10);
        check("stall_req_count", n_req - n0, 4);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_insn_valid", insn_valid, 1);
        check("stall_head_pc", pc, BASE);
        check("stall_head_insn", insn, insn_of(BASE));
        insn_ready = 1'b1;
        step(10);

        // Memory not ready for 3 cycles: request held stable.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_valid", imem_req_valid, 1);
            check("hold_addr", imem_req_addr, BASE + 32'd4);
            step(1);
        end
        imem_req_ready = 1'b1;
        step(1);
        check("resume_addr", imem_req_addr, BASE + 32'd8);
        step(6);

        // Redirect with 2 outstanding, 3-cycle memory.
        lat = 3; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h01000100;
        step(1);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        check("drain_req_valid", imem_req_valid, 0);
        step(1);
        check("drain_req_valid2", imem_req_valid, 0);
        check("drain_insn_valid", insn_valid, 0);
        step(1);
        check("redir_req_valid", imem_req_valid, 1);
        check("redir_req_addr", imem_req_addr, 32'h01000100);
        got = 1'b0; i = 0;
        while (!got && i < 20) begin
            step(1);
            got = insn_valid;
            i++;
        end
        check("redir_first_seen", got, 1);
        check("redir_first_pc", pc, 32'h01000100);
        step(8);

        // Redirect colliding with a response and a pop.
        lat = 1;
        step(10);
        redirect_valid = 1'b1; redirect_pc = 32'h01000200;
        @(negedge clk);
        #1;
        check("pre_rsp_valid", imem_rsp_valid, 1);
        check("pre_insn_valid", insn_valid, 1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("redir_pop_insn_valid", insn_valid, 0);
        step(1);
        check("redir_stale_drop", insn_valid, 0);
        step(10);

        // Reset in the middle of a 3-cycle-latency stream.
        lat = 3;
        step(10);
        rst = 1'b1;
        step(1);
        check("mid_rst_req_valid", imem_req_valid, 0);
        check("mid_rst_insn_valid", insn_valid, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_insn", insn, 0);
        rst = 1'b0;
        #1;
        check("post_rst_req_valid", imem_req_valid, 1);
        check("post_rst_addr", imem_req_addr, BASE);
        lat = 1;
        step(12);

`ifdef FETCH_MISALIGN_EN
        check("misalign_before", misalign, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h01000102;
        step(1);
        redirect_valid = 1'b0;
        check("misalign_set", misalign, 1);
        n0 = n_req;
        step(8);
        check("misalign_no_req", n_req - n0, 0);
        check("misalign_req_valid", imem_req_valid, 0);
        check("misalign_sticky", misalign, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
